// File: rtl/buzzer_scheduler.sv
// buzzer_scheduler
//   Arbitrates the single piezo buzzer between four sources: temperature
//   alarm, clock alarm, hourly chime and key click (highest to lowest).
//   A free-running 1 ms prescaler times the sound durations and the alarm
//   on/off patterns. A free-running tone divider produces the square wave.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   Value_en            one-cycle key-press strobe (key click)
//   ack                 one-cycle stop-key strobe (silences ALARM / TEMP)
//   Hour/Minute/Second  running time, BCD
//   alarmHour/Minute    clock alarm time, BCD; haveAlarm arms it
//   alarmTemp/curTemp   temperature threshold / measurement, BCD;
//                       haveAlarmTemp arms the temperature alarm
//   shouldTick          enables click and chime sounds
//   buzzer              square-wave buzzer drive (registered)
//   active_src          0 idle, 1 click, 2 chime, 3 clock alarm, 4 temp alarm
//   ringing             high while active_src is 3 or 4
module buzzer_scheduler #(
  parameter int unsigned CLK_FREQ = 27000000,
  parameter int unsigned TONE_HZ  = 2000,
  parameter int unsigned CLICK_MS = 30,
  parameter int unsigned CHIME_MS = 500,
  parameter int unsigned ALARM_S  = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Value_en,
  input  logic       ack,
  input  logic [7:0] Hour,
  input  logic [7:0] Minute,
  input  logic [7:0] Second,
  input  logic [7:0] alarmHour,
  input  logic [7:0] alarmMinute,
  input  logic       haveAlarm,
  input  logic       haveAlarmTemp,
  input  logic [7:0] alarmTemp,
  input  logic [7:0] curTemp,
  input  logic       shouldTick,
  output logic       buzzer,
  output logic [2:0] active_src,
  output logic       ringing
);

  localparam int unsigned MS_DIV   = CLK_FREQ / 1000;
  localparam int unsigned TONE_DIV = CLK_FREQ / (2 * TONE_HZ);
  localparam int unsigned MS_W     = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int unsigned TONE_W   = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  localparam logic [MS_W-1:0]   MS_LAST    = MS_W'(MS_DIV - 1);
  localparam logic [TONE_W-1:0] TONE_LAST  = TONE_W'(TONE_DIV - 1);
  localparam logic [16:0]       CLICK_LAST = 17'(CLICK_MS - 1);
  localparam logic [16:0]       CHIME_LAST = 17'(CHIME_MS - 1);
  localparam logic [16:0]       ALARM_LAST = 17'(ALARM_S * 1000 - 1);
  localparam logic [8:0]        ALARM_HALF = 9'd499;
  localparam logic [8:0]        TEMP_HALF  = 9'd249;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLICK = 3'd1,
    S_CHIME = 3'd2,
    S_ALARM = 3'd3,
    S_TEMP  = 3'd4
  } state_t;

  state_t              state, nxt;
  logic [MS_W-1:0]     ms_cnt;
  logic [TONE_W-1:0]   tone_cnt;
  logic                tone;
  logic [7:0]          prev_sec;
  logic [16:0]         dur_cnt;
  logic [8:0]          phase_cnt;
  logic                phase_off;
  logic                temp_mute;

  logic ms_tick, sec_edge, top_of_min;
  logic click_req, chime_req, alarm_req, temp_cond, temp_req;
  logic restart, mute_set, gate;
  logic [8:0] half_last;

  assign ms_tick    = (ms_cnt == MS_LAST);
  assign sec_edge   = (Second != prev_sec);
  assign top_of_min = sec_edge & (Second == 8'h00);
  assign click_req  = Value_en & shouldTick;
  assign chime_req  = top_of_min & (Minute == 8'h00) & shouldTick;
  assign alarm_req  = top_of_min & haveAlarm & (Hour == alarmHour) &
                      (Minute == alarmMinute);
  assign temp_cond  = haveAlarmTemp & (curTemp >= alarmTemp);
  assign temp_req   = temp_cond & ~temp_mute;
  assign half_last  = (state == S_TEMP) ? TEMP_HALF : ALARM_HALF;

  // ack is resolved before any request, so a request arriving together
  // with ack is only seen again from IDLE on the following cycle.
  always_comb begin
    nxt      = state;
    restart  = 1'b0;
    mute_set = 1'b0;
    if (ack && state == S_ALARM) begin
      nxt = S_IDLE;
    end else if (ack && state == S_TEMP) begin
      nxt      = S_IDLE;
      mute_set = 1'b1;
    end else if (temp_req && state != S_TEMP) begin
      nxt     = S_TEMP;
      restart = 1'b1;
    end else if (alarm_req && state != S_TEMP) begin
      nxt     = S_ALARM;   // also restarts an alarm already ringing
      restart = 1'b1;
    end else if (chime_req && (state == S_IDLE || state == S_CLICK)) begin
      nxt     = S_CHIME;
      restart = 1'b1;
    end else if (click_req && state == S_IDLE) begin
      nxt     = S_CLICK;
      restart = 1'b1;
    end else begin
      case (state)
        S_CLICK: if (ms_tick && dur_cnt == CLICK_LAST) nxt = S_IDLE;
        S_CHIME: if (ms_tick && dur_cnt == CHIME_LAST) nxt = S_IDLE;
        S_ALARM: if (ms_tick && dur_cnt == ALARM_LAST) nxt = S_IDLE;
        S_TEMP:  if (!temp_cond) nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    gate = 1'b0;
    case (state)
      S_CLICK, S_CHIME: gate = 1'b1;
      S_ALARM, S_TEMP:  gate = ~phase_off;
      default:          gate = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      active_src <= '0;
      ringing    <= 1'b0;
      buzzer     <= 1'b0;
      ms_cnt     <= '0;
      tone_cnt   <= '0;
      tone       <= 1'b0;
      prev_sec   <= '0;
      dur_cnt    <= '0;
      phase_cnt  <= '0;
      phase_off  <= 1'b0;
      temp_mute  <= 1'b0;
    end else begin
      ms_cnt   <= ms_tick ? '0 : ms_cnt + 1'b1;
      prev_sec <= Second;
      if (tone_cnt == TONE_LAST) begin
        tone_cnt <= '0;
        tone     <= ~tone;
      end else begin
        tone_cnt <= tone_cnt + 1'b1;
      end

      state      <= nxt;
      active_src <= nxt;
      ringing    <= (nxt == S_ALARM) || (nxt == S_TEMP);
      buzzer     <= tone & gate;

      if (restart || nxt == S_IDLE) begin
        dur_cnt   <= '0;
        phase_cnt <= '0;
        phase_off <= 1'b0;
      end else if (ms_tick) begin
        if (dur_cnt != '1) dur_cnt <= dur_cnt + 1'b1;
        if (phase_cnt == half_last) begin
          phase_cnt <= '0;
          phase_off <= ~phase_off;
        end else begin
          phase_cnt <= phase_cnt + 1'b1;
        end
      end

      if (!temp_cond)    temp_mute <= 1'b0;
      else if (mute_set) temp_mute <= 1'b1;
    end
  end

endmodule

// File: tb/tb_buzzer_scheduler.sv
// tb_buzzer_scheduler
//   Randomised scenarios (click, chime, alarm, preemption, temp mute,
//   reset) push expected sound segments into a queue; a monitor closes
//   every active_src segment and compares source, length and buzzer
//   activity against the queued expectation.
module tb_buzzer_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       Value_en = 1'b0, ack = 1'b0;
  logic [7:0] Hour = 8'h12, Minute = 8'h15, Second = 8'h10;
  logic [7:0] alarmHour = 8'h07, alarmMinute = 8'h30;
  logic       haveAlarm = 1'b0, haveAlarmTemp = 1'b0;
  logic [7:0] alarmTemp = 8'h35, curTemp = 8'h20;
  logic       shouldTick = 1'b1;
  logic       buzzer, ringing;
  logic [2:0] active_src;

  buzzer_scheduler #(
    .CLK_FREQ(20000),
    .TONE_HZ (2000),
    .CLICK_MS(3),
    .CHIME_MS(5),
    .ALARM_S (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .Value_en     (Value_en),
    .ack          (ack),
    .Hour         (Hour),
    .Minute       (Minute),
    .Second       (Second),
    .alarmHour    (alarmHour),
    .alarmMinute  (alarmMinute),
    .haveAlarm    (haveAlarm),
    .haveAlarmTemp(haveAlarmTemp),
    .alarmTemp    (alarmTemp),
    .curTemp      (curTemp),
    .shouldTick   (shouldTick),
    .buzzer       (buzzer),
    .active_src   (active_src),
    .ringing      (ringing)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] src;
    int         lmin;
    int         lmax;
    bit         half;   // alarm pattern: only the first half of the ring sounds
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic push(input logic [2:0] s, input int lo, input int hi, input bit half);
    exp_t e;
    e.src = s; e.lmin = lo; e.lmax = hi; e.half = half;
    expq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_src(input logic [2:0] s, input int lim);
    int n;
    n = 0;
    while (active_src != s && n < lim) begin
      tick();
      n++;
    end
    check("wait_src", int'(active_src), int'(s), int'(s));
  endtask

  // Monitor: buzzer at negedge k reflects the state shown at negedge k-1.
  bit         mon_on = 1'b0;
  logic [2:0] prev_src = 3'd0;
  int         seg_len = 0, seg_hi = 0;
  bit         cur_valid = 1'b0;
  exp_t       cur;

  always @(negedge clk) begin
    if (mon_on) begin
      if (buzzer) seg_hi++;
      if (active_src != prev_src) begin
        if (prev_src == 3'd0) begin
          check("idle_quiet", seg_hi, 0, 0);
        end else if (cur_valid) begin
          check("seg_len", seg_len, cur.lmin, cur.lmax);
          if (cur.half) check("seg_hi_half", seg_hi, seg_len / 4 - 12, seg_len / 4 + 12);
          else          check("seg_hi_full", seg_hi, seg_len / 2 - 6, seg_len / 2 + 6);
        end
        cur_valid = 1'b0;
        if (active_src != 3'd0) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_seg actual src=%0d required none", active_src);
          end else begin
            cur = expq.pop_front();
            cur_valid = 1'b1;
            check("seg_src", int'(active_src), int'(cur.src), int'(cur.src));
            check("seg_ringing", int'(ringing), int'(cur.src >= 3'd3), int'(cur.src >= 3'd3));
          end
        end
        seg_len  = 1;
        seg_hi   = 0;
        prev_src = active_src;
      end else begin
        seg_len++;
      end
    end
  end

  initial begin
    int  d, t, k;
    bit  st, chime;
    rst = 1'b1;
    ticks(4);
    check("rst_buzzer", int'(buzzer), 0, 0);
    check("rst_src", int'(active_src), 0, 0);
    check("rst_ringing", int'(ringing), 0, 0);
    rst = 1'b0;
    mon_on = 1'b1;
    ticks(10);

    // Key clicks, some with sound disabled.
    for (int it = 0; it < 4; it++) begin
      ticks($urandom_range(0, 40));
      st = (it == 0) ? 1'b1 : ($urandom % 4 != 0);
      shouldTick = st;
      Value_en = 1'b1;
      if (st) push(3'd1, 40, 61, 1'b0);
      tick();
      Value_en = 1'b0;
      ticks(80);
    end

    // Hourly chime; a key click during the chime is dropped.
    for (int it = 0; it < 3; it++) begin
      shouldTick = (it == 0) ? 1'b1 : 1'($urandom % 2);
      Minute = (it == 0 || $urandom % 2 == 0) ? 8'h00
             : {4'($urandom % 6), 4'(1 + $urandom % 9)};
      Second = 8'h59;
      ticks(5);
      Second = 8'h00;
      chime = (Minute == 8'h00) && shouldTick;
      if (chime) push(3'd2, 80, 101, 1'b0);
      ticks(20);
      Value_en = 1'b1;
      if (!chime && shouldTick) push(3'd1, 40, 61, 1'b0);
      tick();
      Value_en = 1'b0;
      ticks(150);
      Second = 8'h10;
      ticks(10);
    end

    // Alarm at xx:00 beats the chime; ack silences it.
    shouldTick = 1'b1;
    alarmHour = {4'($urandom % 2), 4'($urandom % 10)};
    alarmMinute = 8'h00;
    Hour = alarmHour;
    Minute = 8'h00;
    haveAlarm = 1'b1;
    Second = 8'h59;
    ticks(5);
    Second = 8'h00;
    k = $urandom_range(2000, 6000);
    push(3'd3, k, k + 2, 1'b0);
    wait_src(3'd3, 5);
    ticks(k);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    ticks(20);
    Second = 8'h10;
    ticks(20);

    // Full-length alarm with 500 ms on / off pattern; a click is dropped.
    alarmMinute = {4'($urandom % 6), 4'(1 + $urandom % 9)};
    Minute = alarmMinute;
    Second = 8'h59;
    ticks(5);
    Second = 8'h00;
    push(3'd3, 19980, 20001, 1'b1);
    ticks(3000);
    Value_en = 1'b1;
    tick();
    Value_en = 1'b0;
    ticks(17100);
    Second = 8'h10;
    ticks(20);

    // Temperature alarm preempts a click; the click does not resume.
    haveAlarmTemp = 1'b1;
    alarmTemp = 8'h35;
    curTemp = 8'h20;
    ticks($urandom_range(0, 19));
    d = $urandom_range(15, 35);
    Value_en = 1'b1;
    push(3'd1, d - 1, d + 1, 1'b0);
    tick();
    Value_en = 1'b0;
    ticks(d - 1);
    curTemp = 8'h36 + 8'($urandom % 4);
    t = $urandom_range(1000, 4000);
    push(3'd4, t - 1, t + 1, 1'b0);
    ticks(t);
    curTemp = 8'h34;
    ticks(150);

    // ack mutes the temperature alarm until it drops below threshold.
    curTemp = 8'h36;
    k = $urandom_range(500, 3000);
    push(3'd4, k, k + 2, 1'b0);
    wait_src(3'd4, 5);
    ticks(k);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    ticks(200);
    check("mute_holds", int'(active_src), 0, 0);
    curTemp = 8'h34;
    ticks(3);
    curTemp = 8'h36 + 8'($urandom % 3);
    t = $urandom_range(1000, 4000);
    push(3'd4, t - 1, t + 1, 1'b0);
    ticks(t);
    haveAlarmTemp = 1'b0;
    ticks(50);
    curTemp = 8'h20;

    // Asynchronous reset during an alarm.
    Hour = alarmHour;
    Minute = alarmMinute;
    Second = 8'h59;
    ticks(5);
    Second = 8'h00;
    push(3'd3, 1, 100000, 1'b0);
    wait_src(3'd3, 5);
    ticks(1000);
    rst = 1'b1;
    #1;
    check("async_rst_buzzer", int'(buzzer), 0, 0);
    check("async_rst_src", int'(active_src), 0, 0);
    check("async_rst_ringing", int'(ringing), 0, 0);
    ticks(3);
    rst = 1'b0;
    ticks(200);
    check("idle_after_rst", int'(active_src), 0, 0);

    ticks(20);
    check("exp_drained", expq.size(), 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/buzzer_scheduler.md
Name: buzzer_scheduler

Overview:
- Shares the single piezo buzzer between four sound sources: temperature alarm, clock alarm, hourly chime and key click.
- Sits beside the clock status/keypad controller. Consumes its alarm, temperature and tick-enable settings, plus the running BCD time and the measured temperature.
- Drives one square-wave buzzer pin and reports which source currently owns the buzzer.

Parameters:
- CLK_FREQ, 27000000, system clock in Hz.
- TONE_HZ, 2000, buzzer square-wave frequency.
- CLICK_MS, 30, key-click duration.
- CHIME_MS, 500, hourly-chime duration.
- ALARM_S, 60, maximum clock-alarm ring time in seconds.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- Value_en  in  1  one-cycle key-press strobe.
- ack  in  1  one-cycle "silence" strobe (stop key).
- Hour  in  8  current hour, BCD.
- Minute  in  8  current minute, BCD.
- Second  in  8  current second, BCD.
- alarmHour  in  8  alarm hour, BCD.
- alarmMinute  in  8  alarm minute, BCD.
- haveAlarm  in  1  clock alarm armed.
- haveAlarmTemp  in  1  temperature alarm armed.
- alarmTemp  in  8  temperature threshold, BCD.
- curTemp  in  8  measured temperature, BCD.
- shouldTick  in  1  click/chime sound enable.
- buzzer  out  1  buzzer drive.
- active_src  out  3  0 idle, 1 click, 2 chime, 3 clock alarm, 4 temp alarm.
- ringing  out  1  high while active_src is 3 or 4.

Behaviour:
- Reset values: asserted asynchronously, reset forces buzzer=0, active_src=0, ringing=0, all counters 0, all pending/mute flags 0, FSM to IDLE.
- Reset mid-ring: reset during a ring silences the buzzer immediately. No event survives reset.
- ms tick: a prescaler counts 0..CLK_FREQ/1000-1 and pulses ms_tick for one cycle at terminal count. It free-runs from reset.
- Tone: a counter toggles tone at each CLK_FREQ/(2*TONE_HZ) cycles. It free-runs.
- buzzer output: buzzer = tone AND gate, registered. gate depends on state:
  - CLICK and CHIME: gate is constant 1.
  - ALARM: gate is 500 ms on / 500 ms off, starting on.
  - TEMP: gate is 250 ms on / 250 ms off, starting on.
- Second-edge detection: prev_sec registers Second. sec_edge = (Second != prev_sec).
- Event requests, all sampled every cycle:
  - click_req = Value_en & shouldTick.
  - chime_req = sec_edge & Second==00 & Minute==00 & shouldTick.
  - alarm_req = sec_edge & Second==00 & haveAlarm & Hour==alarmHour & Minute==alarmMinute.
  - temp_cond = haveAlarmTemp & (curTemp >= alarmTemp), an unsigned 8-bit compare, valid for BCD.
  - temp_req = temp_cond & !temp_mute.
- Priority: TEMP > ALARM > CHIME > CLICK.
  - A higher request preempts the current state on the next cycle; the pattern and duration counters restart.
  - The preempted click or chime is discarded.
  - A preempted ALARM is discarded.
  - Lower or equal requests arriving while busy are dropped. Exception: alarm_req during ALARM restarts the ALARM.
- FSM states: IDLE, CLICK, CHIME, ALARM, TEMP. active_src encodes the state.
  - IDLE: go to the highest pending request, else stay.
  - CLICK: exit to IDLE after CLICK_MS ms_ticks.
  - CHIME: exit to IDLE after CHIME_MS ms_ticks.
  - ALARM: exit to IDLE after ALARM_S*1000 ms_ticks, or on ack (next cycle).
  - TEMP: exit to IDLE when temp_cond falls; ack also exits and sets temp_mute.
- temp_mute: clears when temp_cond is 0. The temp alarm re-arms only after the temperature drops below threshold or the alarm is disarmed.
- ack in IDLE, CLICK or CHIME has no effect.
- Simultaneous events: chime_req and alarm_req in the same cycle (alarm at xx:00) → ALARM wins. ack and a new request in the same cycle → ack processed first; the request is evaluated from IDLE next cycle.
- Latency: request at cycle n → active_src updated at n+1 → buzzer may toggle from n+2.
- Duration counter: 17 bits wide, counting ms; saturates and does not wrap.

Test Plan:
Sim parameters: CLK_FREQ=20000, TONE_HZ=2000 (tone period 10 cycles), CLICK_MS=3, CHIME_MS=5, ALARM_S=1.
- Click: Value_en pulse, shouldTick=1 → active_src=1 for 3 ms (60 cycles ±1 prescaler phase); buzzer toggles every 5 cycles; then 0. Same pulse with shouldTick=0 → buzzer stays 0.
- Hourly chime: Second 59→00 with Minute=00 → active_src=2 for 5 ms. Same edge with Minute=01 → no sound.
- Clock alarm: alarm 07:30 armed, time steps 07:29:59→07:30:00 → active_src=3, ringing=1, gate 500 ms on/off, ends after 1000 ms. Repeat with ack at 200 ms → idle next cycle.
- Preemption: a click in progress, then curTemp=36 with alarmTemp=35 and haveAlarmTemp=1 → active_src=4 on the next cycle. The click is not resumed after TEMP ends.
- Temp mute: in TEMP, ack → IDLE and no re-entry while curTemp=36. curTemp=34 then 36 → TEMP again.
- Reset: assert rst during ALARM → buzzer=0, active_src=0 immediately (asynchronous). Release rst → stays idle.
